sms4_round_sched: RTL

- Iterative SMS4 round sequencer with block-level valid/ready handshake.
- Accepts one 128-bit block and runs 32 rounds, one per cycle, through one shared round datapath: X(i+4) = X(i) ^ L(tau(X(i+1)^X(i+2)^X(i+3)^rk(i))).
- Round keys come from an external key store via an indexed request/valid handshake. The S-box lookup is an external combinational table.
- Sits between the block I/O wrapper and the key-expansion RAM. The linear transform L (rotations by 2/10/18/24 XORed with B) is built inside this block.

---
 rtl/sms4_round_sched.sv | 107 ++++++++++
 1 files changed

// File: rtl/sms4_round_sched.sv
// SMS4 iterative round sequencer: one round per cycle through a shared datapath,
// with round keys fetched by index from an external key store.
module sms4_round_sched #(
   parameter int BWIDTH  = 32,
   parameter int NROUNDS = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                decrypt,
   input  logic [0:4*BWIDTH-1] din,
   output logic [0:4]          rk_idx,
   input  logic [0:BWIDTH-1]   rk_in,
   input  logic                rk_valid,
   output logic [0:BWIDTH-1]   sbox_in,
   input  logic [0:BWIDTH-1]   sbox_out,
   output logic                busy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [0:4*BWIDTH-1] dout
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [4:0] LAST = 5'(NROUNDS - 1);

   state_t            state;
   logic [4:0]        cnt;
   logic              dec_q;
   logic [0:BWIDTH-1] x0, x1, x2, x3;
   logic [0:BWIDTH-1] t;
   logic [0:BWIDTH-1] x_new;

   // Decrypt walks the same key schedule backwards.
   assign rk_idx  = dec_q ? (LAST - cnt) : cnt;
   assign sbox_in = x1 ^ x2 ^ x3 ^ rk_in;

   // Bit 0 is the MSB, so a left rotate by n is the slice [n:31] followed by [0:n-1].
   assign t = sbox_out
            ^ {sbox_out[2:31],  sbox_out[0:1]}
            ^ {sbox_out[10:31], sbox_out[0:9]}
            ^ {sbox_out[18:31], sbox_out[0:17]}
            ^ {sbox_out[24:31], sbox_out[0:23]};

   assign x_new = x0 ^ t;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         dout      <= '0;
         cnt       <= '0;
         dec_q     <= 1'b0;
         x0        <= '0;
         x1        <= '0;
         x2        <= '0;
         x3        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x0       <= din[0:BWIDTH-1];
                  x1       <= din[BWIDTH:2*BWIDTH-1];
                  x2       <= din[2*BWIDTH:3*BWIDTH-1];
                  x3       <= din[3*BWIDTH:4*BWIDTH-1];
                  dec_q    <= decrypt;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (rk_valid) begin
                  x0 <= x1;
                  x1 <= x2;
                  x2 <= x3;
                  x3 <= x_new;
                  // The final round's result leaves in reversed word order.
                  if (cnt == LAST) begin
                     dout      <= {x_new, x3, x2, x1};
                     out_valid <= 1'b1;
                     busy      <= 1'b0;
                     state     <= DONE;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
